// File: rtl/data_types.sv
// Shared datapath types for the common data bus and its per-unit result buffers.
package data_types;

    localparam int unsigned N_FU_DEFAULT = 4;
    localparam int unsigned TAG_W        = 4;

    typedef logic [TAG_W-1:0] rs_tag_t;
    typedef logic [31:0]      word32_t;

    // Tag value reserved to mean "no result on the bus".
    localparam rs_tag_t NO_VAL = '0;

    typedef struct packed {
        rs_tag_t tag;
        word32_t val;
    } cdb_t;

    typedef struct packed {
        rs_tag_t tag;
        word32_t val;
        logic    spec;
    } fifo_entry_t;

endpackage

// File: rtl/cdb_fifo.sv
// Per-unit result buffer: FIFO with flush of speculative entries and commit of spec marks.
module cdb_fifo
    import data_types::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = AW + 1
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        push_i,
    input  fifo_entry_t push_entry_i,
    input  logic        pop_i,
    input  logic        flush_i,
    input  logic        commit_i,
    output fifo_entry_t head_o,
    output logic [CW-1:0] count_o
);

    fifo_entry_t   mem_q [DEPTH];
    fifo_entry_t   mem_n [DEPTH];
    logic [AW-1:0] head_q, head_n;
    logic [CW-1:0] cnt_q, cnt_n;
    logic [CW-1:0] kept;
    logic [AW-1:0] idx;

    always_comb begin
        mem_n  = mem_q;
        head_n = head_q;
        cnt_n  = cnt_q;
        kept   = '0;
        idx    = '0;
        if (flush_i) begin
            // Survivors are repacked from slot 0 in original order; a popped head is skipped.
            for (int unsigned i = 0; i < DEPTH; i++) begin
                idx = head_q + AW'(i);
                if ((CW'(i) < cnt_q) && !mem_q[idx].spec && !(pop_i && (i == 0))) begin
                    mem_n[kept[AW-1:0]] = mem_q[idx];
                    kept = kept + CW'(1);
                end
            end
            if (push_i) begin
                mem_n[kept[AW-1:0]] = push_entry_i;
                kept = kept + CW'(1);
            end
            head_n = '0;
            cnt_n  = kept;
        end else begin
            if (push_i) begin
                mem_n[head_q + cnt_q[AW-1:0]] = push_entry_i;
            end
            if (commit_i) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    mem_n[i].spec = 1'b0;
                end
            end
            if (pop_i) begin
                head_n = head_q + AW'(1);
            end
            cnt_n = cnt_q + CW'(push_i) - CW'(pop_i);
        end
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_n;
        if (reset_i) begin
            head_q <= '0;
            cnt_q  <= '0;
        end else begin
            head_q <= head_n;
            cnt_q  <= cnt_n;
        end
    end

    assign head_o  = mem_q[head_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter draining per-unit result buffers onto a registered common data bus.
module cdb_arbiter
    import data_types::*;
#(
    parameter int unsigned N_FU      = N_FU_DEFAULT,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [N_FU-1:0]     fu_valid_i,
    input  rs_tag_t [N_FU-1:0]  fu_tag_i,
    input  word32_t [N_FU-1:0]  fu_val_i,
    input  logic [N_FU-1:0]     fu_spec_i,
    output logic [N_FU-1:0]     fu_ready_o,
    input  logic                flush_i,
    input  logic                commit_i,
    output cdb_t                cdb_o
);

    localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;
    localparam int unsigned RW = (N_FU > 1) ? $clog2(N_FU) : 1;

    fifo_entry_t     head     [N_FU];
    fifo_entry_t     push_ent [N_FU];
    logic [CW-1:0]   cnt      [N_FU];
    logic [N_FU-1:0] push, pop, eligible;

    logic [RW-1:0] rr_q, rr_n, cand;
    logic          found;
    cdb_t          cdb_q, cdb_n;

    for (genvar k = 0; k < N_FU; k++) begin : g_fu
        assign fu_ready_o[k] = (cnt[k] < CW'(BUF_DEPTH));
        // Speculative offers arriving with a flush are dropped; NO_VAL offers never enter.
        assign push[k] = fu_valid_i[k] && fu_ready_o[k] && (fu_tag_i[k] != NO_VAL)
                         && !(flush_i && fu_spec_i[k]);
        assign push_ent[k] = '{tag: fu_tag_i[k], val: fu_val_i[k], spec: fu_spec_i[k]};
        assign eligible[k] = (cnt[k] != '0) && !(flush_i && head[k].spec);

        cdb_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
            .clk_i        (clk_i),
            .reset_i      (reset_i),
            .push_i       (push[k]),
            .push_entry_i (push_ent[k]),
            .pop_i        (pop[k]),
            .flush_i      (flush_i),
            .commit_i     (commit_i),
            .head_o       (head[k]),
            .count_o      (cnt[k])
        );
    end

    always_comb begin
        found     = 1'b0;
        pop       = '0;
        cand      = '0;
        rr_n      = rr_q;
        cdb_n.tag = NO_VAL;
        cdb_n.val = cdb_q.val;
        for (int unsigned off = 0; off < N_FU; off++) begin
            cand = RW'((32'(rr_q) + off) % N_FU);
            if (!found && eligible[cand]) begin
                found      = 1'b1;
                pop[cand]  = 1'b1;
                cdb_n.tag  = head[cand].tag;
                cdb_n.val  = head[cand].val;
                rr_n       = (32'(cand) == N_FU - 1) ? '0 : cand + RW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rr_q      <= '0;
            cdb_q.tag <= NO_VAL;
            cdb_q.val <= '0;
        end else begin
            rr_q  <= rr_n;
            cdb_q <= cdb_n;
        end
    end

    assign cdb_o = cdb_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized bench for cdb_arbiter against a queue-based model of the buffering and arbitration rules.
module tb_cdb_arbiter;
    import data_types::*;

    localparam int N = 4;
    localparam int D = 2;

    typedef struct {
        rs_tag_t tag;
        word32_t val;
        logic    spec;
    } ent_t;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     fu_valid;
    rs_tag_t [N-1:0]  fu_tag;
    word32_t [N-1:0]  fu_val;
    logic [N-1:0]     fu_spec;
    logic [N-1:0]     fu_ready;
    logic             flush, commit;
    cdb_t             cdb;

    ent_t q [N][$];
    int   rr;
    bit   model_valid = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    cdb_arbiter #(.N_FU(N), .BUF_DEPTH(D)) dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .fu_valid_i (fu_valid),
        .fu_tag_i   (fu_tag),
        .fu_val_i   (fu_val),
        .fu_spec_i  (fu_spec),
        .fu_ready_o (fu_ready),
        .flush_i    (flush),
        .commit_i   (commit),
        .cdb_o      (cdb)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, obs, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        reset = 0; flush = 0; commit = 0;
        fu_valid = '0; fu_spec = '0;
        for (int k = 0; k < N; k++) begin
            fu_tag[k] = NO_VAL;
            fu_val[k] = '0;
        end
    endtask

    task automatic offer(input int k, input int tag, input logic [31:0] val, input logic spec);
        fu_valid[k] = 1'b1;
        fu_tag[k]   = rs_tag_t'(tag);
        fu_val[k]   = val;
        fu_spec[k]  = spec;
    endtask

    // One clock edge: check ready, advance the model with the current inputs, then check the bus.
    task automatic tick();
        rs_tag_t  exp_tag;
        word32_t  exp_val;
        bit       chk_val;
        int       gnt;
        ent_t     e;
        ent_t     tmp[$];
        bit       rdy[N];
        exp_tag = NO_VAL;
        exp_val = '0;
        chk_val = 0;
        if (model_valid) begin
            for (int k = 0; k < N; k++)
                check_eq($sformatf("ready%0d", k), 64'(fu_ready[k]), 64'(q[k].size() < D));
        end
        if (reset) begin
            for (int k = 0; k < N; k++) q[k].delete();
            rr = 0;
            chk_val = 1;
            model_valid = 1;
        end else begin
            for (int k = 0; k < N; k++) rdy[k] = (q[k].size() < D);
            gnt = -1;
            for (int off = 0; off < N; off++) begin
                int c;
                c = (rr + off) % N;
                if (gnt < 0 && q[c].size() > 0 && !(flush && q[c][0].spec)) gnt = c;
            end
            if (gnt >= 0) begin
                e = q[gnt].pop_front();
                exp_tag = e.tag;
                exp_val = e.val;
                chk_val = 1;
                rr = (gnt + 1) % N;
            end
            for (int k = 0; k < N; k++) begin
                if (flush) begin
                    tmp.delete();
                    for (int j = 0; j < q[k].size(); j++)
                        if (!q[k][j].spec) tmp.push_back(q[k][j]);
                    q[k] = tmp;
                end else if (commit) begin
                    for (int j = 0; j < q[k].size(); j++) q[k][j].spec = 1'b0;
                end
            end
            for (int k = 0; k < N; k++) begin
                if (fu_valid[k] && rdy[k] && fu_tag[k] != NO_VAL && !(flush && fu_spec[k])) begin
                    e.tag  = fu_tag[k];
                    e.val  = fu_val[k];
                    e.spec = fu_spec[k] && !commit;
                    q[k].push_back(e);
                end
            end
        end
        @(posedge clk);
        #1;
        check_eq("cdb_tag", 64'(cdb.tag), 64'(exp_tag));
        if (chk_val) check_eq("cdb_val", 64'(cdb.val), 64'(exp_val));
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        tick();
        reset = 0;
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        tick();
        idle_inputs();
        tick();

        // Single uncontended result: two edges of latency, one bus cycle.
        offer(2, 5, 32'hDEAD_BEEF, 0);
        tick();
        idle_inputs();
        tick();
        check_eq("d_lat_tag", 64'(cdb.tag), 64'd5);
        check_eq("d_lat_val", 64'(cdb.val), 64'hDEAD_BEEF);
        tick();
        check_eq("d_lat_idle", 64'(cdb.tag), 64'(NO_VAL));

        // Four simultaneous offers drain in round-robin order.
        do_reset();
        for (int k = 0; k < N; k++) offer(k, k + 1, 32'h100 + 32'(k), 0);
        tick();
        idle_inputs();
        for (int k = 0; k < N; k++) begin
            tick();
            check_eq($sformatf("d_rr_%0d", k), 64'(cdb.tag), 64'(k + 1));
        end
        tick();
        check_eq("d_rr_idle", 64'(cdb.tag), 64'(NO_VAL));

        // Full buffer on unit 0 back-pressures while other units are granted.
        do_reset();
        offer(0, 1, 32'h1, 0); tick();
        idle_inputs(); tick();
        offer(0, 6, 32'h6, 0); offer(1, 8, 32'h8, 0); offer(2, 12, 32'hC, 0); offer(3, 13, 32'hD, 0);
        tick();
        idle_inputs(); offer(0, 10, 32'hA, 0); tick();
        check_eq("d_full_rdy0", 64'(fu_ready[0]), 64'd0);
        offer(0, 14, 32'hE, 0); tick();
        tick();
        tick();
        check_eq("d_full_pop", 64'(cdb.tag), 64'd6);
        check_eq("d_full_rdy0_back", 64'(fu_ready[0]), 64'd1);
        idle_inputs(); tick();
        check_eq("d_full_next", 64'(cdb.tag), 64'd10);
        tick();

        // Flush keeps the non-speculative entry and drops the speculative one behind it.
        do_reset();
        offer(0, 2, 32'h2, 0); offer(1, 7, 32'h7, 0); tick();
        idle_inputs(); offer(1, 9, 32'h9, 1); tick();
        idle_inputs(); flush = 1; tick();
        check_eq("d_flush_keep", 64'(cdb.tag), 64'd7);
        idle_inputs(); tick();
        check_eq("d_flush_drop", 64'(cdb.tag), 64'(NO_VAL));

        // Flush wins over a simultaneous commit.
        do_reset();
        offer(0, 2, 32'h2, 0); offer(3, 3, 32'h3, 1); tick();
        idle_inputs(); flush = 1; commit = 1; tick();
        check_eq("d_prec_grant", 64'(cdb.tag), 64'd2);
        idle_inputs(); tick();
        check_eq("d_prec_drop", 64'(cdb.tag), 64'(NO_VAL));

        // Reset mid-operation discards buffered results.
        do_reset();
        offer(0, 5, 32'h5, 0); offer(1, 6, 32'h6, 0); offer(2, 7, 32'h7, 0); tick();
        idle_inputs(); reset = 1; tick();
        check_eq("d_rst_tag", 64'(cdb.tag), 64'(NO_VAL));
        idle_inputs();
        check_eq("d_rst_ready", 64'(fu_ready), 64'hF);
        for (int i = 0; i < 3; i++) tick();

        // Randomized traffic with occasional flush, commit and reset.
        for (int c = 0; c < 3000; c++) begin
            reset  = ($urandom_range(0, 199) == 0);
            flush  = ($urandom_range(0, 15) == 0);
            commit = ($urandom_range(0, 9) == 0);
            for (int k = 0; k < N; k++) begin
                fu_valid[k] = 1'($urandom_range(0, 1));
                fu_tag[k]   = rs_tag_t'($urandom_range(0, 15));
                fu_val[k]   = $urandom;
                fu_spec[k]  = ($urandom_range(0, 2) == 0);
            end
            tick();
        end
        idle_inputs();
        for (int i = 0; i < 12; i++) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter N_FU, default 4: number of functional-unit result producers feeding the common data bus.
REQ-002 Parameter BUF_DEPTH, default 2: result-buffer entries per functional unit; power of two, at least 2.
REQ-003 Port clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 Port reset_i  input  1  reset, synchronous and active-high.
REQ-005 Port fu_valid_i  input  N_FU  per-unit result-offer strobe.
REQ-006 Port fu_tag_i  input  N_FU x rs_tag_t  producing reservation-station tag, per unit.
REQ-007 Port fu_val_i  input  N_FU x word32_t  result value, per unit.
REQ-008 Port fu_spec_i  input  N_FU  result produced under an unresolved branch, per unit.
REQ-009 Port fu_ready_o  output  N_FU  per-unit buffer can accept a result this cycle.
REQ-010 Port flush_i  input  1  branch mispredict: discard speculative buffered results.
REQ-011 Port commit_i  input  1  branch resolved correctly: clear speculative marks.
REQ-012 Port cdb_o  output  cdb_t  registered broadcast {tag, val}; tag NO_VAL means idle.

Function
REQ-013 A result SHALL be accepted from unit k on a rising edge where fu_valid_i[k] & fu_ready_o[k] & (fu_tag_i[k] != NO_VAL).
REQ-014 Offers with tag NO_VAL SHALL be dropped silently, with no buffer change.
REQ-015 fu_ready_o[k] SHALL be high exactly when buffer k holds fewer than BUF_DEPTH entries; it is derived from registered count only, never from the same-cycle pop.
REQ-016 Each buffer SHALL be FIFO-ordered: {tag, val, spec} written at the tail, read from the head; pointers wrap modulo BUF_DEPTH.
REQ-017 On each edge at most one non-empty buffer SHALL be granted; its head is popped and registered onto cdb_o.
REQ-018 Grant SHALL be round-robin: search starts at pointer rr, ascending modulo N_FU; after a grant to k, rr becomes (k+1) mod N_FU; rr does not move on idle cycles.
REQ-019 With no non-empty buffer, cdb_o.tag SHALL be NO_VAL on the next edge; cdb_o.val is don't-care.
REQ-020 Minimum latency SHALL be 2 edges: accepted at edge E, uncontended, the result is on cdb_o after edge E+1 for exactly one cycle.
REQ-021 A simultaneous push and pop on the same non-full buffer SHALL both take effect; count is unchanged.
REQ-022 Every accepted result SHALL be broadcast exactly once unless discarded by flush_i.
REQ-023 When flush_i is high, all buffered entries with spec=1 SHALL be invalidated on that edge; spec=0 entries keep relative order and stay buffered.
REQ-024 During a flush edge, no spec=1 entry SHALL be granted; cdb_o carries either a spec=0 head or NO_VAL.
REQ-025 Same-cycle offers with fu_spec_i=1 during flush_i SHALL be dropped; spec=0 offers are accepted normally.
REQ-026 commit_i SHALL clear spec on all buffered entries; spec=1 offers arriving that same edge are stored with spec=0.
REQ-027 If flush_i and commit_i are both high, flush_i SHALL take precedence.

Reset
REQ-028 On reset_i, all buffers SHALL become empty, rr = 0, cdb_o.tag = NO_VAL and cdb_o.val = 0, effective the edge reset_i is sampled high.
REQ-029 fu_ready_o SHALL be all ones in the cycle after reset; in-flight results are discarded when reset is asserted mid-operation.

Structure
REQ-030 cdb_t, rs_tag_t, word32_t and NO_VAL SHALL come from data_types; N_FU_DEFAULT SHALL be added there.
REQ-031 The per-unit buffer SHALL be a sub-module cdb_fifo (push, pop, flush of spec entries, commit, count); it is instantiated N_FU times.
REQ-032 The arbiter, rr pointer and cdb_o register SHALL live in cdb_arbiter.

Verification
REQ-033 Reset, then unit 2 offers tag 5 / val 0xDEAD_BEEF, non-speculative -> after 2 edges, cdb_o = {5, 0xDEAD_BEEF} for one cycle, then NO_VAL.
REQ-034 All 4 units offer tags 1..4 on the same edge with rr=0 -> broadcasts in order 1,2,3,4 on consecutive cycles; rr ends at 0.
REQ-035 Unit 0 holds BUF_DEPTH=2 entries and the arbiter grants another unit -> fu_ready_o[0]=0 and a third offer is not accepted; ready rises once one entry pops.
REQ-036 Unit 1 buffer holds {tag 7, spec=0} then {tag 9, spec=1}, and flush_i pulses -> tag 7 is broadcast and tag 9 never appears on cdb_o.
REQ-037 Spec entry tag 3 is buffered and commit_i pulses in the same cycle as flush_i -> tag 3 is discarded (flush precedence).
REQ-038 Reset is asserted with 3 buffered results -> cdb_o.tag = NO_VAL, all ready high, none of the 3 results is ever broadcast.
